// File: rtl/mux_pipe_pkg.sv
// Shared pipeline-control types and constants for the mux_pipe slice.
package mux_pipe_pkg;

  // Occupancy of the two-entry head/skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_DEPTH = 2;

endpackage

// File: rtl/muxn.sv
// Purpose: combinational N-way select with out-of-range detect.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller qualifies the result with its handshake.
module muxn #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    s,
  output logic [WIDTH-1:0]   y,
  output logic               sel_err
);

  always_comb begin
    y       = '0;
    sel_err = (int'(s) >= N);
    for (int k = 0; k < N; k++) begin
      if (s == SELW'(k)) y = d[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_pipe.sv
// Purpose: registered N-way mux behind a 2-entry head/skid buffer.
// Latency: 1 cycle when empty; sustains 1 beat/cycle with out_ready high.
// Backpressure: in_ready is registered (state != FULL), never combinational on out_ready.
module mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    s,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   y,
  output logic               sel_err,
  output logic               out_valid,
  input  logic               out_ready
);

  pipe_state_e      state, state_nxt;
  logic [WIDTH-1:0] mux_y, head_dat, skid_dat;
  logic             mux_err, head_err, skid_err, in_ready_q;
  logic             accept, xfer;
  logic             load_head_new, load_head_skid, load_skid;

  muxn #(.WIDTH(WIDTH), .N(N)) u_muxn (
    .d       (d),
    .s       (s),
    .y       (mux_y),
    .sel_err (mux_err)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state != ST_EMPTY);
  assign y         = head_dat;
  assign sel_err   = head_err;
  assign accept    = in_valid && in_ready_q;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt     = ST_ONE;
          load_head_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          load_head_new = 1'b1;
        end else if (accept) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (xfer) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          state_nxt      = ST_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush beats any same-cycle accept: the offered beat is dropped.
    if (flush) begin
      state_nxt      = ST_EMPTY;
      load_head_new  = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      head_dat   <= '0;
      head_err   <= 1'b0;
      skid_dat   <= '0;
      skid_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
      if (load_head_new) begin
        head_dat <= mux_y;
        head_err <= mux_err;
      end else if (load_head_skid) begin
        head_dat <= skid_dat;
        head_err <= skid_err;
      end
      if (load_skid) begin
        skid_dat <= mux_y;
        skid_err <= mux_err;
      end
    end
  end

endmodule

// File: tb/tb_mux_pipe.sv
// Directed and random checks of mux_pipe with N=4 and N=3 instances.
module tb_mux_pipe;

  logic         clk;
  logic         reset;

  logic [127:0] d0;
  logic [1:0]   s0;
  logic         iv0, ir0, fl0, se0, ov0, or0;
  logic [31:0]  y0;

  logic [95:0]  d3;
  logic [1:0]   s3;
  logic         iv3, ir3, fl3, se3, ov3, or3;
  logic [31:0]  y3;

  int tests = 0;
  int fails = 0;

  mux_pipe #(.WIDTH(32), .N(4)) u0 (
    .clk(clk), .reset(reset), .d(d0), .s(s0), .in_valid(iv0), .in_ready(ir0),
    .flush(fl0), .y(y0), .sel_err(se0), .out_valid(ov0), .out_ready(or0)
  );

  mux_pipe #(.WIDTH(32), .N(3)) u3 (
    .clk(clk), .reset(reset), .d(d3), .s(s3), .in_valid(iv3), .in_ready(ir3),
    .flush(fl3), .y(y3), .sel_err(se3), .out_valid(ov3), .out_ready(or3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference for the N=3 instance: {sel_err, y}.
  function automatic logic [32:0] ref3(input logic [95:0] dv, input logic [1:0] sv);
    logic [32:0] r;
    if (sv < 2'd3) r = {1'b0, dv[sv*32 +: 32]};
    else           r = {1'b1, 32'h0};
    return r;
  endfunction

  initial begin
    logic [32:0] q[$];
    logic [32:0] exp_b;
    logic        acc, xfr, stalled;
    logic [31:0] prev_y;
    logic        prev_e;

    reset = 1'b1;
    d0 = '0; s0 = '0; iv0 = 0; fl0 = 0; or0 = 0;
    d3 = '0; s3 = '0; iv3 = 0; fl3 = 0; or3 = 0;
    step();
    step();
    reset = 1'b0;
    chk("rst_out_valid", ov0, 0);
    chk("rst_in_ready",  ir0, 1);
    chk("rst_y",         y0,  0);
    chk("rst_sel_err",   se0, 0);
    step();
    chk("post_rst_out_valid", ov0, 0);

    // Basic select, channel 2.
    d0  = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    s0  = 2'd2; iv0 = 1; or0 = 1;
    step();
    iv0 = 0;
    chk("sel2_y",         y0,  32'hCCCC_CCCC);
    chk("sel2_out_valid", ov0, 1);
    chk("sel2_sel_err",   se0, 0);
    step();
    chk("sel2_drained", ov0, 0);

    // N=3: in-range then out-of-range select.
    d3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    s3 = 2'd1; iv3 = 1; or3 = 1;
    step();
    s3 = 2'd3;
    chk("n3_s1_y",   y3,  32'h2222_2222);
    chk("n3_s1_err", se3, 0);
    step();
    iv3 = 0;
    chk("n3_s3_y",   y3,  0);
    chk("n3_s3_err", se3, 1);
    chk("n3_s3_vld", ov3, 1);
    step();
    chk("n3_s3_once", ov3, 0);

    // Backpressure: beats 1,2,3 with out_ready low.
    or0 = 0; s0 = 2'd0; iv0 = 1;
    d0 = 128'd1;
    step();
    chk("bp_b1_in_ready", ir0, 1);
    d0 = 128'd2;
    step();
    chk("bp_full_in_ready", ir0, 0);
    chk("bp_full_y",        y0,  1);
    d0 = 128'd3;
    step();
    chk("bp_hold_in_ready", ir0, 0);
    chk("bp_hold_y",        y0,  1);
    or0 = 1;
    step();
    chk("bp_drain_y2",  y0,  2);
    chk("bp_drain_rdy", ir0, 1);
    step();
    iv0 = 0;
    chk("bp_drain_y3", y0,  3);
    chk("bp_drain_v3", ov0, 1);
    step();
    chk("bp_drain_empty", ov0, 0);

    // Flush in FULL with a beat offered.
    or0 = 0; iv0 = 1;
    d0 = 128'h11; step();
    d0 = 128'h22; step();
    fl0 = 1; d0 = 128'h99;
    chk("fl_full_in_ready_pre", ir0, 0);
    step();
    fl0 = 0; iv0 = 0;
    chk("fl_full_out_valid", ov0, 0);
    chk("fl_full_in_ready",  ir0, 1);
    or0 = 1;
    step();
    chk("fl_full_no_beat", ov0, 0);

    // Flush in ONE wins over a simultaneous accept.
    or0 = 0; iv0 = 1; d0 = 128'h33;
    step();
    fl0 = 1; d0 = 128'h44;
    step();
    fl0 = 0; iv0 = 0; or0 = 1;
    chk("fl_one_out_valid", ov0, 0);
    step();
    chk("fl_one_no_beat", ov0, 0);

    // Random run on the N=3 instance against a queue model.
    stalled = 0; prev_y = '0; prev_e = 0;
    for (int c = 0; c < 1000; c++) begin
      iv3 = 1'($urandom_range(0, 1));
      or3 = ($urandom_range(0, 3) != 0);
      s3  = 2'($urandom_range(0, 3));
      d3  = {$urandom, $urandom, $urandom};
      chk("rnd_out_valid", ov3, (q.size() != 0));
      chk("rnd_in_ready",  ir3, (q.size() < 2));
      if (q.size() != 0) begin
        chk("rnd_y",   y3,  q[0][31:0]);
        chk("rnd_err", se3, q[0][32]);
      end
      if (stalled) begin
        chk("rnd_stall_y",   y3,  prev_y);
        chk("rnd_stall_err", se3, prev_e);
      end
      acc     = iv3 && (q.size() < 2);
      xfr     = (q.size() != 0) && or3;
      stalled = (q.size() != 0) && !or3;
      prev_y  = y3;
      prev_e  = se3;
      exp_b   = ref3(d3, s3);
      step();
      if (xfr) void'(q.pop_front());
      if (acc) q.push_back(exp_b);
    end
    iv3 = 0; or3 = 1;

    // Reset while FULL.
    or0 = 0; iv0 = 1;
    d0 = 128'h55; step();
    d0 = 128'h66; step();
    chk("rstf_pre_full", ir0, 0);
    reset = 1; or0 = 1;
    step();
    reset = 0; iv0 = 0;
    chk("rstf_out_valid", ov0, 0);
    chk("rstf_y",         y0,  0);
    chk("rstf_sel_err",   se0, 0);
    chk("rstf_in_ready",  ir0, 1);
    step();
    chk("rstf_no_beat", ov0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
